// File: rtl/ahb3_sram_slave_if.sv
// AHB3-Lite slave-side bus bundle: address/control, write data and the slave response.
interface ahb3_sram_slave_if #(
  parameter int ADD_width  = 32,
  parameter int DATA_width = 32,
  parameter int RESP_width = 1
);
  logic                  hsel;
  logic [ADD_width-1:0]  haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic [DATA_width-1:0] hwdata;
  logic                  hready;
  logic                  hreadyout;
  logic [RESP_width-1:0] hresp;
  logic [DATA_width-1:0] hrdata;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
    output hreadyout, hresp, hrdata
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb3_sram_slave.sv
// AHB3-Lite SRAM slave with byte-lane writes, WAIT_STATES wait cycles per OKAY beat and a two-cycle ERROR.
// Data arrives 1+WAIT_STATES cycles after the address phase; hreadyout stays low through waits and ERR1.
module ahb3_sram_slave #(
  parameter int ADD_width   = 32,
  parameter int DATA_width  = 32,
  parameter int RESP_width  = 1,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0,
  parameter int PROT_CHECK  = 0,
  parameter int PRIV_BYTES  = 64
) (
  input logic              clk,
  input logic              resetn,
  ahb3_sram_slave_if.slave bus
);
  localparam int NB  = DATA_width / 8;
  localparam int LSB = $clog2(NB);
  localparam int AW  = $clog2(MEM_DEPTH);
  localparam logic [ADD_width:0] MEM_BYTES = (ADD_width + 1)'(MEM_DEPTH * NB);
  localparam logic [ADD_width:0] PRIV_LIM  = (ADD_width + 1)'(PRIV_BYTES);
  localparam logic [3:0]         WS        = 4'(WAIT_STATES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_XFER, S_ERR1, S_ERR2} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [ADD_width-1:0]  addr_q;
  logic [2:0]            size_q;
  logic                  write_q;
  logic                  accept;
  logic                  done;
  logic                  misalign;
  logic                  bad;
  logic [NB-1:0]         lane_en;
  logic [AW-1:0]         word_idx;
  logic [DATA_width-1:0] mem [MEM_DEPTH];
  logic                  unused;

  assign accept = bus.hsel && bus.hready && bus.htrans[1];
  assign done   = (state == S_IDLE) || (state == S_XFER) || (state == S_ERR2);

  always_comb begin
    misalign = 1'b0;
    for (int i = 0; i < LSB; i++) begin
      if (3'(i) < bus.hsize && bus.haddr[i]) misalign = 1'b1;
    end
    bad = ({1'b0, bus.haddr} >= MEM_BYTES) || (bus.hsize > 3'(LSB)) || misalign ||
          ((PROT_CHECK != 0) && bus.hwrite && !bus.hprot[1] && ({1'b0, bus.haddr} < PRIV_LIM));
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = S_XFER;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_ERR1: state_nxt = S_ERR2;
      default: begin
        // IDLE, XFER and ERR2 all close a data phase, so a new beat may start here without a bubble
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        if (accept) begin
          if (bad) begin
            state_nxt = S_ERR1;
          end else if (WS != 4'd0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = WS;
          end else begin
            state_nxt = S_XFER;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept && done) begin
        addr_q  <= bus.haddr;
        size_q  <= bus.hsize;
        write_q <= bus.hwrite;
      end
    end
  end

  always_comb begin
    lane_en = '0;
    for (int i = 0; i < NB; i++) begin
      if (i >= int'(addr_q[LSB-1:0]) && i < int'(addr_q[LSB-1:0]) + (1 << size_q)) lane_en[i] = 1'b1;
    end
  end

  assign word_idx = addr_q[LSB +: AW];

  // Memory is deliberately not reset; a reset edge that lands on XFER drops the write.
  always_ff @(posedge clk) begin
    if (resetn && state == S_XFER && write_q) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_en[i]) mem[word_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
    end
  end

  assign bus.hreadyout = done;
  assign bus.hrdata    = (state == S_XFER && !write_q) ? mem[word_idx] : '0;

  always_comb begin
    bus.hresp    = '0;
    bus.hresp[0] = (state == S_ERR1) || (state == S_ERR2);
  end

  assign unused = ^{bus.hburst, bus.hprot[3:2], bus.hprot[0], addr_q[ADD_width-1:LSB+AW]};
endmodule

// File: tb/tb_ahb3_sram_slave.sv
// Bench for ahb3_sram_slave: two slaves on one shared AHB bus (A: zero-wait with privilege check, B: 3 wait states).
module tb_ahb3_sram_slave;
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        priv;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } beat_t;

  logic        clk;
  logic        resetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        cur;
  logic        stall;

  int checks = 0;
  int failures = 0;
  int data_cycles = 0;
  beat_t q[$];
  beat_t tbl [20];
  logic [7:0] mdl [2][1024];

  ahb3_sram_slave_if ifa ();
  ahb3_sram_slave_if ifb ();

  ahb3_sram_slave #(.WAIT_STATES(0), .PROT_CHECK(1), .PRIV_BYTES(64)) dut_a (
    .clk(clk), .resetn(resetn), .bus(ifa.slave));
  ahb3_sram_slave #(.WAIT_STATES(3), .PROT_CHECK(0)) dut_b (
    .clk(clk), .resetn(resetn), .bus(ifb.slave));

  logic        rdy;
  logic        rsp;
  logic [31:0] rdat;
  assign rdy  = cur ? ifb.hreadyout : ifa.hreadyout;
  assign rsp  = cur ? ifb.hresp[0]  : ifa.hresp[0];
  assign rdat = cur ? ifb.hrdata    : ifa.hrdata;

  assign ifa.hsel = hsel & ~cur;
  assign ifb.hsel = hsel & cur;
  assign ifa.haddr = haddr;   assign ifb.haddr = haddr;
  assign ifa.htrans = htrans; assign ifb.htrans = htrans;
  assign ifa.hwrite = hwrite; assign ifb.hwrite = hwrite;
  assign ifa.hsize = hsize;   assign ifb.hsize = hsize;
  assign ifa.hburst = hburst; assign ifb.hburst = hburst;
  assign ifa.hprot = hprot;   assign ifb.hprot = hprot;
  assign ifa.hwdata = hwdata; assign ifb.hwdata = hwdata;
  assign ifa.hready = rdy & ~stall;
  assign ifb.hready = rdy & ~stall;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed memory and the transfer legality rules, applied in program order.
  task automatic model_apply(inout beat_t b, input int which);
    int nb;
    int a;
    int base;
    nb = 1 << b.size;
    a = int'(b.addr);
    b.err = (a >= 1024) || (nb > 4) || (a % nb != 0) || (which == 0 && b.wr && !b.priv && a < 64);
    b.rdata = 0;
    if (!b.err) begin
      if (b.wr) begin
        for (int k = 0; k < nb; k++) mdl[which][a+k] = b.wdata[8*((a+k)%4) +: 8];
      end else begin
        base = a - a % 4;
        for (int k = 0; k < 4; k++) b.rdata[8*k +: 8] = mdl[which][base+k];
      end
    end
  endtask

  // At a negedge: wait for the selected slave's ready, checking the pending beat's response.
  task automatic wait_data(input bit have_prev, input beat_t prev);
    int w;
    int ws;
    logic first_resp;
    w = 0;
    ws = cur ? 3 : 0;
    first_resp = 1'b0;
    forever begin
      if (w == 0) first_resp = rsp;
      if (rdy) break;
      if (w > 20) begin
        checks++;
        failures++;
        $display("FAIL ready_timeout: hreadyout still 0 after %0d cycles, required 1", w);
        break;
      end
      @(posedge clk);
      @(negedge clk);
      w++;
    end
    if (have_prev) begin
      chk($sformatf("waits@%h", prev.addr), 32'(w), prev.err ? 32'd1 : 32'(ws));
      chk($sformatf("resp_first@%h", prev.addr), {31'd0, first_resp}, {31'd0, prev.err});
      chk($sformatf("resp_last@%h", prev.addr), {31'd0, rsp}, {31'd0, prev.err});
      chk($sformatf("rdata@%h", prev.addr), rdat, (prev.err || prev.wr) ? 32'd0 : prev.rdata);
      data_cycles += w + 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pipelined master: beat i's address phase overlaps beat i-1's data phase.
  task automatic run_q(input bit burst);
    beat_t prev;
    bit have_prev;
    int n;
    have_prev = 1'b0;
    prev = '0;
    n = q.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        hsel   = 1'b1;
        htrans = (burst && i > 0) ? 2'b11 : 2'b10;
        haddr  = q[i].addr;
        hwrite = q[i].wr;
        hsize  = q[i].size;
        hprot  = {2'b00, q[i].priv, 1'b1};
        hburst = burst ? 3'b001 : 3'b000;
      end else begin
        hsel   = 1'b0;
        htrans = 2'b00;
      end
      hwdata = have_prev ? prev.wdata : 32'd0;
      wait_data(have_prev, prev);
      if (i < n) begin
        prev = q[i];
        have_prev = 1'b1;
      end
    end
    q.delete();
  endtask

  task automatic push_model(input beat_t b, input int which);
    beat_t t;
    t = b;
    model_apply(t, which);
    q.push_back(t);
  endtask

  task automatic gen_rand(input int which, input int n);
    beat_t b;
    int r;
    for (int i = 0; i < n; i++) begin
      b = '0;
      b.wr = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 15);
      b.size = (r == 0) ? 3'd3 : 3'(r % 3);
      b.addr = 32'($urandom_range(0, 1100));
      if ($urandom_range(0, 7) != 0) b.addr = b.addr & ~((32'd1 << b.size) - 32'd1);
      b.priv = 1'($urandom_range(0, 1));
      b.wdata = $urandom;
      push_model(b, which);
    end
  endtask

  initial begin
    beat_t b;
    tbl = '{
      '{1'b1, 32'h10,  3'd2, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0},
      '{1'b0, 32'h10,  3'd2, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF},
      '{1'b1, 32'h20,  3'd2, 1'b1, 32'h11223344, 1'b0, 32'h0},
      '{1'b1, 32'h21,  3'd0, 1'b1, 32'h0000AA00, 1'b0, 32'h0},
      '{1'b1, 32'h22,  3'd1, 1'b1, 32'hBBCC0000, 1'b0, 32'h0},
      '{1'b0, 32'h20,  3'd2, 1'b0, 32'h0,        1'b0, 32'hBBCCAA44},
      '{1'b1, 32'h30,  3'd2, 1'b1, 32'h55667788, 1'b0, 32'h0},
      '{1'b0, 32'h400, 3'd2, 1'b0, 32'h0,        1'b1, 32'h0},
      '{1'b1, 32'h31,  3'd1, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0},
      '{1'b0, 32'h03,  3'd1, 1'b0, 32'h0,        1'b1, 32'h0},
      '{1'b1, 32'h30,  3'd3, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0},
      '{1'b1, 32'h400, 3'd2, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0},
      '{1'b0, 32'h30,  3'd2, 1'b0, 32'h0,        1'b0, 32'h55667788},
      '{1'b1, 32'h3C,  3'd2, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0},
      '{1'b1, 32'h3C,  3'd2, 1'b0, 32'h12345678, 1'b1, 32'h0},
      '{1'b0, 32'h3C,  3'd2, 1'b0, 32'h0,        1'b0, 32'hCAFEF00D},
      '{1'b1, 32'h40,  3'd2, 1'b0, 32'h0BADC0DE, 1'b0, 32'h0},
      '{1'b0, 32'h40,  3'd2, 1'b0, 32'h0,        1'b0, 32'h0BADC0DE},
      '{1'b0, 32'h3D,  3'd0, 1'b0, 32'h0,        1'b0, 32'hCAFEF00D},
      '{1'b1, 32'h3F,  3'd0, 1'b0, 32'hEEEEEEEE, 1'b1, 32'h0}
    };
    resetn = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; hwdata = '0; cur = 1'b0; stall = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy_a", {31'd0, ifa.hreadyout}, 32'd1);
    chk("rst_resp_a", {31'd0, ifa.hresp[0]}, 32'd0);
    chk("rst_rdata_a", ifa.hrdata, 32'd0);
    chk("rst_rdy_b", {31'd0, ifb.hreadyout}, 32'd1);
    chk("rst_resp_b", {31'd0, ifb.hresp[0]}, 32'd0);
    chk("rst_rdata_b", ifb.hrdata, 32'd0);
    resetn = 1'b1;

    // Give every word a known value so random reads are fully predictable.
    for (int which = 0; which < 2; which++) begin
      cur = 1'(which);
      for (int w = 0; w < 256; w++) begin
        b = '0;
        b.wr = 1'b1; b.addr = 32'(w * 4); b.size = 3'd2; b.priv = 1'b1; b.wdata = $urandom;
        push_model(b, which);
      end
      run_q(1'b1);
    end

    cur = 1'b0;
    for (int i = 0; i < 20; i++) begin
      b = tbl[i];
      model_apply(b, 0);
      q.push_back(tbl[i]);
    end
    run_q(1'b0);

    // Zero-wait slave streams one beat per cycle.
    for (int i = 0; i < 8; i++) begin
      b = '0;
      b.wr = 1'b1; b.addr = 32'($urandom_range(16, 255) * 4); b.size = 3'd2; b.priv = 1'b1; b.wdata = $urandom;
      push_model(b, 0);
    end
    data_cycles = 0;
    run_q(1'b1);
    chk("throughput_a", 32'(data_cycles), 32'd8);

    // Four SEQ read beats on the 3-wait slave.
    cur = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      b = '0;
      b.addr = 32'(i * 4); b.size = 3'd2;
      push_model(b, 1);
    end
    data_cycles = 0;
    run_q(1'b1);
    chk("burst_cycles_b", 32'(data_cycles), 32'd16);

    // Write presented while another slave holds hready low, then BUSY/IDLE: nothing may be accepted.
    cur = 1'b0;
    stall = 1'b1; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
    hprot = 4'b0011; hwdata = 32'h0;
    @(posedge clk); @(negedge clk);
    stall = 1'b0; htrans = 2'b01;
    @(posedge clk); @(negedge clk);
    chk("busy_rdy", {31'd0, rdy}, 32'd1);
    chk("busy_resp", {31'd0, rsp}, 32'd0);
    htrans = 2'b00;
    @(posedge clk); @(negedge clk);
    chk("idle_rdy", {31'd0, rdy}, 32'd1);
    hsel = 1'b0;
    b = '0; b.addr = 32'h10; b.size = 3'd2;
    push_model(b, 0);
    run_q(1'b0);

    // Reset while a write sits in its wait states: the write must be dropped.
    cur = 1'b1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h50; hsize = 3'd2; hprot = 4'b0011;
    @(posedge clk); @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hA5A5A5A5;
    chk("midwait_rdy", {31'd0, rdy}, 32'd0);
    resetn = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("postrst_rdy", {31'd0, ifb.hreadyout}, 32'd1);
    chk("postrst_resp", {31'd0, ifb.hresp[0]}, 32'd0);
    chk("postrst_rdata", ifb.hrdata, 32'd0);
    resetn = 1'b1;
    b = '0; b.addr = 32'h50; b.size = 3'd2;
    push_model(b, 1);
    run_q(1'b0);

    for (int c = 0; c < 40; c++) begin
      cur = 1'(c % 4 == 3);
      gen_rand(int'(cur), $urandom_range(1, 10));
      run_q(1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
